int_issue_queue: RTL and testbench
==================================

Name: int_issue_queue

Overview:
Reservation station directly upstream of the integer execution unit.
- Holds dispatched integer and branch instructions until both source operands are available.
- Snoops the common data bus for wakeup.
- Issues at most one instruction per cycle, oldest ready first, through registered outputs that drive the execution unit's inputs directly.

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAG_W, 6, physical/ROB tag width
XLEN, 32, operand width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  branch-mispredict flush; empties queue
dispatch_en  in  1  dispatch request
dispatch_ready  out  1  queue not full; dispatch accepted when dispatch_en && dispatch_ready
d_opcode  in  7  opcode
d_funct3  in  3  funct3
d_funct7  in  7  funct7
d_rs1_data  in  XLEN  rs1 value (meaningful when d_rs1_rdy)
d_rs1_tag  in  TAG_W  rs1 producer tag
d_rs1_rdy  in  1  rs1 value valid
d_rs2_data  in  XLEN  rs2 value (meaningful when d_rs2_rdy)
d_rs2_tag  in  TAG_W  rs2 producer tag
d_rs2_rdy  in  1  rs2 value valid
d_rd_tag  in  TAG_W  destination tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_data  in  XLEN  CDB data
issue_int  out  1  issued instruction valid
Opcode  out  7  issued opcode
Funct3  out  3  issued funct3
Funct7  out  7  issued funct7
RS1  out  XLEN  issued rs1 value
RS2  out  XLEN  issued rs2 value
RD_Tag  out  TAG_W  issued destination tag
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
Reset (rst_n=0 at edge):
- All entries invalid, count=0.
- issue_int=0; Opcode/Funct3/Funct7/RS1/RS2/RD_Tag = 0.
- dispatch_ready=1 after reset.

Storage:
- Age-ordered compacting queue; entry 0 is oldest.
- Fields per entry: valid, opcode, funct3, funct7, rs1/rs2 data, tag and rdy, rd_tag.

dispatch_ready:
- Combinational: (count < DEPTH) && !flush.
- Registered count only; a same-cycle issue does not free a slot for that cycle's dispatch.

Dispatch:
- An accepted dispatch is written at the next edge into slot count, or count-1 if an issue leaves the same cycle.

Wakeup (every cycle, cdb_valid=1):
- For every valid entry with an operand not ready whose tag == cdb_tag, capture cdb_data and set rdy at the next edge.
- The same wakeup applies to an incoming dispatch operand (d_rsX_rdy=0, d_rsX_tag == cdb_tag): it is written ready with cdb_data.
- A woken operand is eligible for selection the cycle after capture. There is no same-cycle CDB-to-issue bypass.

Select/issue:
- Combinationally pick the lowest-index valid entry with rs1_rdy && rs2_rdy.
- At the next edge, register its fields onto the issue outputs with issue_int=1, remove it, and shift younger entries down by one.
- With no ready entry, issue_int=0 and the other issue outputs are 0.
- issue_int is a one-cycle pulse per instruction. The downstream unit is always able to accept, so there is no back-pressure.

Latency:
- A dispatch accepted at edge k with both operands ready appears on issue_int after edge k+1, if it is the oldest ready entry.

count:
- Next value = count + accepted dispatch - issue.
- Never exceeds DEPTH; never underflows.

Flush:
- flush=1 at edge clears all entries and count, and forces issue_int=0 with outputs 0.
- Dispatch in the same cycle is dropped.
- rst_n=0 dominates flush.

Branches:
- B_TYPE entries are issued like any other. RD_Tag is carried unchanged; result suppression belongs to the execution unit.

Operand tags:
- Tags of ready operands are ignored and never matched.

Test Plan:
- Reset, then dispatch ADD (opcode 0110011, f3 0, f7 0, RS1=5, RS2=7, both rdy, rd_tag 3) -> one cycle later issue_int=1, RS1=5, RS2=7, RD_Tag=3 for exactly one cycle; count 1->0.
- Dispatch with rs1_rdy=0 tag 9, then 3 idle cycles, then cdb_valid tag 9 data 0x10 -> issue_int=1 two cycles after the CDB beat with RS1=0x10; no issue before.
- Dispatch while cdb_valid tag 9 data 0xAA and d_rs2_tag=9, d_rs2_rdy=0 -> entry captured ready; issues next cycle with RS2=0xAA.
- Fill 4 entries, all waiting on tag 1 -> count=4, dispatch_ready=0, fifth dispatch ignored. CDB tag 1 -> entries issue on 4 consecutive cycles in dispatch order (rd_tags 10,11,12,13).
- Older entry waiting (tag 2), younger entry ready -> younger issues first; the older issues after CDB tag 2, and the order of the remaining entries is preserved.
- Three entries queued, assert flush together with dispatch_en -> next cycle count=0, issue_int=0, dispatched instruction never issues. Repeat with rst_n=0 mid-operation -> all outputs 0.

Source files
------------

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered compacting reservation station in front of the integer unit.
// It picks the oldest ready entry, wakes operands from the CDB, and registers the issue outputs.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         dispatch_en,
  output logic                         dispatch_ready,
  input  logic [6:0]                   d_opcode,
  input  logic [2:0]                   d_funct3,
  input  logic [6:0]                   d_funct7,
  input  logic [XLEN-1:0]              d_rs1_data,
  input  logic [TAG_W-1:0]             d_rs1_tag,
  input  logic                         d_rs1_rdy,
  input  logic [XLEN-1:0]              d_rs2_data,
  input  logic [TAG_W-1:0]             d_rs2_tag,
  input  logic                         d_rs2_rdy,
  input  logic [TAG_W-1:0]             d_rd_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         issue_int,
  output logic [6:0]                   Opcode,
  output logic [2:0]                   Funct3,
  output logic [6:0]                   Funct7,
  output logic [XLEN-1:0]              RS1,
  output logic [XLEN-1:0]              RS2,
  output logic [TAG_W-1:0]             RD_Tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rd_tag;
  } entry_t;

  // A ready operand keeps its value; a waiting one captures the CDB value on a tag match.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cd);
    entry_t r;
    logic   hit1;
    logic   hit2;
    hit1       = cv && !e.rs1_rdy && (e.rs1_tag == ct);
    hit2       = cv && !e.rs2_rdy && (e.rs2_tag == ct);
    r          = e;
    r.rs1_rdy  = e.rs1_rdy | hit1;
    r.rs1_data = hit1 ? cd : e.rs1_data;
    r.rs2_rdy  = e.rs2_rdy | hit2;
    r.rs2_data = hit2 ? cd : e.rs2_data;
    return r;
  endfunction

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           wake_ent [DEPTH];
  entry_t           shift_ent [DEPTH];
  entry_t           new_ent;
  logic [DEPTH-1:0] rdy_vec;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             accept;
  logic [CW-1:0]    wr_slot;
  logic [CW-1:0]    count_q, count_d;
  logic             issue_int_q, issue_int_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [TAG_W-1:0] rd_tag_q, rd_tag_d;

  assign dispatch_ready = (count_q < CW'(DEPTH)) && !flush;
  assign accept         = dispatch_en && dispatch_ready;

  // Oldest-ready select over the registered entries (no same-cycle CDB bypass)
  always_comb begin
    rdy_vec   = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_vec[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
      sel_found  = sel_found | rdy_vec[i];
      sel_idx    = rdy_vec[i] ? IW'(i) : sel_idx;
    end
  end

  // Wakeup, compaction behind the issued slot, and dispatch insertion
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.opcode   = d_opcode;
    new_ent.funct3   = d_funct3;
    new_ent.funct7   = d_funct7;
    new_ent.rs1_data = d_rs1_data;
    new_ent.rs1_tag  = d_rs1_tag;
    new_ent.rs1_rdy  = d_rs1_rdy;
    new_ent.rs2_data = d_rs2_data;
    new_ent.rs2_tag  = d_rs2_tag;
    new_ent.rs2_rdy  = d_rs2_rdy;
    new_ent.rd_tag   = d_rd_tag;
    new_ent          = wake(new_ent, cdb_valid, cdb_tag, cdb_data);
    // An issue leaving this cycle moves the tail down, so the new entry lands one slot lower.
    wr_slot          = count_q - CW'(sel_found);
    for (int i = 0; i < DEPTH; i++) begin
      wake_ent[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_ent[i] = wake_ent[i + 1];
    end
    shift_ent[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        ent_d[i] = '0;
      end else if (accept && (wr_slot == CW'(i))) begin
        ent_d[i] = new_ent;
      end else if (sel_found && (i >= int'(sel_idx))) begin
        ent_d[i] = shift_ent[i];
      end else begin
        ent_d[i] = wake_ent[i];
      end
    end
  end

  // Next issue-output register values and occupancy
  always_comb begin
    issue_int_d = 1'b0;
    opcode_d    = '0;
    funct3_d    = '0;
    funct7_d    = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_tag_d    = '0;
    if (sel_found && !flush) begin
      issue_int_d = 1'b1;
      opcode_d    = ent_q[sel_idx].opcode;
      funct3_d    = ent_q[sel_idx].funct3;
      funct7_d    = ent_q[sel_idx].funct7;
      rs1_d       = ent_q[sel_idx].rs1_data;
      rs2_d       = ent_q[sel_idx].rs2_data;
      rd_tag_d    = ent_q[sel_idx].rd_tag;
    end else begin
      issue_int_d = 1'b0;
    end
    count_d = flush ? {CW{1'b0}} : (count_q + CW'(accept) - CW'(sel_found));
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q     <= '0;
      issue_int_q <= 1'b0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_tag_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q     <= count_d;
      issue_int_q <= issue_int_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  assign issue_int = issue_int_q;
  assign Opcode    = opcode_q;
  assign Funct3    = funct3_q;
  assign Funct7    = funct7_q;
  assign RS1       = rs1_q;
  assign RS2       = rs2_q;
  assign RD_Tag    = rd_tag_q;
  assign count     = count_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed vector table for the corner cases, then random
// stimulus checked against a queue-based reference model.
module tb_int_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic             clk = 1'b0;
  logic             rst_n, flush, dispatch_en, dispatch_ready;
  logic [6:0]       d_opcode, d_funct7;
  logic [2:0]       d_funct3;
  logic [XLEN-1:0]  d_rs1_data, d_rs2_data, cdb_data;
  logic [TAG_W-1:0] d_rs1_tag, d_rs2_tag, d_rd_tag, cdb_tag;
  logic             d_rs1_rdy, d_rs2_rdy, cdb_valid;
  logic             issue_int;
  logic [6:0]       Opcode, Funct7;
  logic [2:0]       Funct3;
  logic [XLEN-1:0]  RS1, RS2;
  logic [TAG_W-1:0] RD_Tag;
  logic [2:0]       count;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_en(dispatch_en),
    .dispatch_ready(dispatch_ready), .d_opcode(d_opcode), .d_funct3(d_funct3),
    .d_funct7(d_funct7), .d_rs1_data(d_rs1_data), .d_rs1_tag(d_rs1_tag),
    .d_rs1_rdy(d_rs1_rdy), .d_rs2_data(d_rs2_data), .d_rs2_tag(d_rs2_tag),
    .d_rs2_rdy(d_rs2_rdy), .d_rd_tag(d_rd_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .issue_int(issue_int),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .RS1(RS1), .RS2(RS2),
    .RD_Tag(RD_Tag), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    bit              rst_n;
    bit              flush;
    bit              den;
    logic [6:0]      op;
    logic [31:0]     r1d;
    logic [5:0]      r1t;
    bit              r1r;
    logic [31:0]     r2d;
    logic [5:0]      r2t;
    bit              r2r;
    logic [5:0]      rd;
    bit              cv;
    logic [5:0]      ct;
    logic [31:0]     cd;
    bit              chk_rdy;
    bit              e_rdy;
    bit              e_iss;
    logic [6:0]      e_op;
    logic [31:0]     e_rs1;
    logic [31:0]     e_rs2;
    logic [5:0]      e_rd;
    int              e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;

  function automatic vec_t blank();
    vec_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  task automatic d(input logic [6:0] op, input logic [31:0] r1d, input logic [5:0] r1t,
                   input bit r1r, input logic [31:0] r2d, input logic [5:0] r2t,
                   input bit r2r, input logic [5:0] rd);
    cur.den = 1'b1; cur.op = op;
    cur.r1d = r1d; cur.r1t = r1t; cur.r1r = r1r;
    cur.r2d = r2d; cur.r2t = r2t; cur.r2r = r2r;
    cur.rd  = rd;
  endtask

  task automatic cb(input logic [5:0] t, input logic [31:0] dat);
    cur.cv = 1'b1; cur.ct = t; cur.cd = dat;
  endtask

  // Row with no issue expected; rdy < 0 skips the dispatch_ready check.
  task automatic e(input int rdy, input int cnt);
    cur.chk_rdy = (rdy >= 0); cur.e_rdy = (rdy == 1); cur.e_iss = 1'b0;
    cur.e_cnt = cnt;
    tbl.push_back(cur);
    cur = blank();
  endtask

  task automatic ei(input int rdy, input logic [6:0] op, input logic [31:0] rs1,
                    input logic [31:0] rs2, input logic [5:0] rd, input int cnt);
    cur.chk_rdy = 1'b1; cur.e_rdy = (rdy == 1); cur.e_iss = 1'b1;
    cur.e_op = op; cur.e_rs1 = rs1; cur.e_rs2 = rs2; cur.e_rd = rd; cur.e_cnt = cnt;
    tbl.push_back(cur);
    cur = blank();
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; flush = v.flush; dispatch_en = v.den;
    d_opcode = v.op; d_funct3 = 3'd0; d_funct7 = 7'd0;
    d_rs1_data = v.r1d; d_rs1_tag = v.r1t; d_rs1_rdy = v.r1r;
    d_rs2_data = v.r2d; d_rs2_tag = v.r2t; d_rs2_rdy = v.r2r;
    d_rd_tag = v.rd; cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
  endtask

  // Reference model: a plain age-ordered list of waiting instructions.
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r1d;
    logic [5:0]  r1t;
    bit          r1r;
    logic [31:0] r2d;
    logic [5:0]  r2t;
    bit          r2r;
    logic [5:0]  rd;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_iss;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic [31:0] m_rs1, m_rs2;
  logic [5:0]  m_rd;

  function automatic m_ent_t m_wake(input m_ent_t x);
    m_ent_t y;
    y = x;
    if (cdb_valid && !x.r1r && x.r1t == cdb_tag) begin y.r1r = 1'b1; y.r1d = cdb_data; end
    if (cdb_valid && !x.r2r && x.r2t == cdb_tag) begin y.r2r = 1'b1; y.r2d = cdb_data; end
    return y;
  endfunction

  task automatic model_step();
    int     n;
    int     idx;
    bit     acc;
    m_ent_t ne;
    m_iss = 1'b0; m_op = '0; m_f3 = '0; m_f7 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      n   = mq.size();
      acc = dispatch_en && (n < DEPTH);
      idx = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (idx < 0 && mq[i].r1r && mq[i].r2r) idx = i;
      end
      if (idx >= 0) begin
        m_iss = 1'b1; m_op = mq[idx].op; m_f3 = mq[idx].f3; m_f7 = mq[idx].f7;
        m_rs1 = mq[idx].r1d; m_rs2 = mq[idx].r2d; m_rd = mq[idx].rd;
        mq.delete(idx);
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
      if (acc) begin
        ne.op = d_opcode; ne.f3 = d_funct3; ne.f7 = d_funct7;
        ne.r1d = d_rs1_data; ne.r1t = d_rs1_tag; ne.r1r = d_rs1_rdy;
        ne.r2d = d_rs2_data; ne.r2t = d_rs2_tag; ne.r2r = d_rs2_rdy;
        ne.rd = d_rd_tag;
        mq.push_back(m_wake(ne));
      end
    end
  endtask

  initial begin
    cur = blank();
    // Reset, then a ready ADD issues one cycle after it is accepted.
    cur.rst_n = 1'b0; e(-1, 0);
    d(OP_ADD, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3); e(1, 1);
    ei(1, OP_ADD, 32'd5, 32'd7, 6'd3, 0);
    e(1, 0);
    // rs1 waits on tag 9; wakes from the CDB after idle cycles.
    d(OP_ADD, 32'h99, 6'd9, 1'b0, 32'd7, 6'd0, 1'b1, 6'd4); e(1, 1);
    e(1, 1); e(1, 1); e(1, 1);
    cb(6'd9, 32'h10); e(1, 1);
    ei(1, OP_ADD, 32'h10, 32'd7, 6'd4, 0);
    e(1, 0);
    // Dispatch-time wakeup of rs2; a branch carries its RD_Tag through.
    d(OP_BR, 32'd1, 6'd0, 1'b1, 32'd5, 6'd9, 1'b0, 6'd5); cb(6'd9, 32'hAA); e(1, 1);
    ei(1, OP_BR, 32'd1, 32'hAA, 6'd5, 0);
    // Fill to DEPTH waiting on tag 1; a fifth dispatch is refused.
    for (int k = 0; k < 4; k++) begin
      d(OP_ADD, 32'd0, 6'd1, 1'b0, 32'(10 + k), 6'd0, 1'b1, 6'(10 + k)); e(1, k + 1);
    end
    d(OP_ADD, 32'd1, 6'd0, 1'b1, 32'd14, 6'd0, 1'b1, 6'd14); e(0, 4);
    cb(6'd1, 32'h55); e(0, 4);
    for (int k = 0; k < 4; k++) begin
      ei((k == 0) ? 0 : 1, OP_ADD, 32'h55, 32'(10 + k), 6'(10 + k), 3 - k);
    end
    e(1, 0);
    // Younger ready entry overtakes an older waiting one; order of the rest preserved.
    d(OP_ADD, 32'd0, 6'd2, 1'b0, 32'h20, 6'd0, 1'b1, 6'd20); e(1, 1);
    d(OP_ADD, 32'h31, 6'd0, 1'b1, 32'h32, 6'd0, 1'b1, 6'd21); e(1, 2);
    d(OP_ADD, 32'd0, 6'd2, 1'b0, 32'h40, 6'd0, 1'b1, 6'd22); ei(1, OP_ADD, 32'h31, 32'h32, 6'd21, 2);
    cb(6'd2, 32'h77); e(1, 2);
    ei(1, OP_ADD, 32'h77, 32'h20, 6'd20, 1);
    ei(1, OP_ADD, 32'h77, 32'h40, 6'd22, 0);
    e(1, 0);
    // Flush with a same-cycle dispatch drops everything.
    for (int k = 0; k < 3; k++) begin
      d(OP_ADD, 32'd0, 6'd5, 1'b0, 32'(k), 6'd0, 1'b1, 6'(30 + k)); e(1, k + 1);
    end
    d(OP_ADD, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd33); cur.flush = 1'b1; e(0, 0);
    e(1, 0);
    cb(6'd5, 32'd1); e(1, 0);
    e(1, 0);
    // Flush suppresses an issue that would otherwise happen.
    d(OP_ADD, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd40); e(1, 1);
    cur.flush = 1'b1; e(0, 0);
    e(1, 0);
    // Reset in the middle of operation clears an in-flight issue.
    d(OP_ADD, 32'h41, 6'd0, 1'b1, 32'h42, 6'd0, 1'b1, 6'd41); e(1, 1);
    d(OP_ADD, 32'h43, 6'd0, 1'b1, 32'h44, 6'd0, 1'b1, 6'd42); ei(1, OP_ADD, 32'h41, 32'h42, 6'd41, 1);
    d(OP_ADD, 32'h45, 6'd0, 1'b1, 32'h46, 6'd0, 1'b1, 6'd43); cur.rst_n = 1'b0; e(1, 0);
    e(1, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      apply(tbl[n]);
      @(negedge clk);
      if (tbl[n].chk_rdy) chk($sformatf("row%0d_ready", n), 64'(dispatch_ready), 64'(tbl[n].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_issue", n), 64'(issue_int), 64'(tbl[n].e_iss));
      chk($sformatf("row%0d_opcode", n), 64'(Opcode), 64'(tbl[n].e_op));
      chk($sformatf("row%0d_rs1", n), 64'(RS1), 64'(tbl[n].e_rs1));
      chk($sformatf("row%0d_rs2", n), 64'(RS2), 64'(tbl[n].e_rs2));
      chk($sformatf("row%0d_rdtag", n), 64'(RD_Tag), 64'(tbl[n].e_rd));
      chk($sformatf("row%0d_count", n), 64'(count), 64'(tbl[n].e_cnt));
    end

    // Random traffic against the reference model.
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n       = (cyc == 0) ? 1'b0 : ($urandom_range(63) != 0);
      flush       = ($urandom_range(31) == 0);
      dispatch_en = $urandom_range(1);
      d_opcode    = $urandom_range(1) ? OP_ADD : OP_BR;
      d_funct3    = 3'($urandom);
      d_funct7    = 7'($urandom);
      d_rs1_data  = $urandom;
      d_rs1_tag   = 6'($urandom_range(3));
      d_rs1_rdy   = $urandom_range(1);
      d_rs2_data  = $urandom;
      d_rs2_tag   = 6'($urandom_range(3));
      d_rs2_rdy   = $urandom_range(1);
      d_rd_tag    = 6'($urandom);
      cdb_valid   = $urandom_range(1);
      cdb_tag     = 6'($urandom_range(3));
      cdb_data    = $urandom;
      @(negedge clk);
      if (cyc > 0) chk("rnd_ready", 64'(dispatch_ready), 64'((mq.size() < DEPTH) && !flush));
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_issue", 64'(issue_int), 64'(m_iss));
      chk("rnd_opcode", 64'(Opcode), 64'(m_op));
      chk("rnd_funct3", 64'(Funct3), 64'(m_f3));
      chk("rnd_funct7", 64'(Funct7), 64'(m_f7));
      chk("rnd_rs1", 64'(RS1), 64'(m_rs1));
      chk("rnd_rs2", 64'(RS2), 64'(m_rs2));
      chk("rnd_rdtag", 64'(RD_Tag), 64'(m_rd));
      chk("rnd_count", 64'(count), 64'(mq.size()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
